// File: rtl/qcl_edge_pkg.sv
// qcl_edge_pkg: shared types and sizing helpers for the edge event capture block
package qcl_edge_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } e_edge_mode;

    function automatic int cnt_width(input int filter);
        return (filter > 1) ? $clog2(filter) : 1;
    endfunction

endpackage

// File: rtl/qcl_dff_reset.sv
// qcl_dff_reset: register with synchronous active-high reset to a fixed value
module qcl_dff_reset #(
    parameter int                 width_p     = 1,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    always_ff @(posedge clk_i) q_o <= reset_i ? reset_val_p : d_i;

endmodule

// File: rtl/qcl_edge_filter_chan.sv
// qcl_edge_filter_chan: one channel of glitch filter, edge detect and sticky pending/overflow flags
module qcl_edge_filter_chan
    import qcl_edge_pkg::*;
#(
    parameter int filter_p    = 1,
    parameter bit reset_val_p = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    input  logic rise_en_i,
    input  logic fall_en_i,
    input  logic clear_i,
    output logic detect_o,
    output logic level_o,
    output logic pending_o,
    output logic overflow_o
);

    localparam int               cw_lp   = cnt_width(filter_p);
    localparam logic [cw_lp-1:0] last_lp = cw_lp'(filter_p - 1);

    logic [cw_lp-1:0] cnt_q, cnt_d;
    logic [2:0]       flags_q, flags_d;
    logic             diff, accept;

    assign {level_o, pending_o, overflow_o} = flags_q;

    // with filter_p == 1 the counter never leaves zero, so accept reduces to diff
    always_comb begin
        diff     = sig_i != level_o;
        accept   = diff && (cnt_q == last_lp);
        detect_o = !reset_i && accept && (sig_i ? rise_en_i : fall_en_i);
        cnt_d    = (diff && !accept) ? cnt_q + 1'b1 : '0;
        flags_d  = {accept ? sig_i : level_o,
                    (pending_o && !clear_i) || detect_o,
                    (overflow_o || (detect_o && pending_o)) && !clear_i};
    end

    qcl_dff_reset #(.width_p(cw_lp), .reset_val_p('0)) u_cnt (
        .clk_i(clk_i), .reset_i(reset_i), .d_i(cnt_d), .q_o(cnt_q)
    );

    qcl_dff_reset #(.width_p(3), .reset_val_p({reset_val_p, 2'b00})) u_flags (
        .clk_i(clk_i), .reset_i(reset_i), .d_i(flags_d), .q_o(flags_q)
    );

endmodule

// File: rtl/qcl_edge_event_capture.sv
// qcl_edge_event_capture: multi-channel filtered edge detector with sticky pending/overflow and irq
module qcl_edge_event_capture
    import qcl_edge_pkg::*;
#(
    parameter int width_p     = 8,
    parameter int filter_p    = 1,
    parameter bit reset_val_p = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] sig_i,
    input  logic [width_p-1:0] rise_en_i,
    input  logic [width_p-1:0] fall_en_i,
    input  logic [width_p-1:0] clear_i,
    output logic [width_p-1:0] detect_o,
    output logic [width_p-1:0] level_o,
    output logic [width_p-1:0] pending_o,
    output logic [width_p-1:0] overflow_o,
    output logic               irq_o
);

    for (genvar i = 0; i < width_p; i++) begin : g_chan
        qcl_edge_filter_chan #(.filter_p(filter_p), .reset_val_p(reset_val_p)) u_chan (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .sig_i     (sig_i[i]),
            .rise_en_i (rise_en_i[i]),
            .fall_en_i (fall_en_i[i]),
            .clear_i   (clear_i[i]),
            .detect_o  (detect_o[i]),
            .level_o   (level_o[i]),
            .pending_o (pending_o[i]),
            .overflow_o(overflow_o[i])
        );
    end

    assign irq_o = |pending_o;

endmodule

// File: tb/tb_qcl_edge_event_capture.sv
// tb_qcl_edge_event_capture: three configurations driven in parallel, checked against a streak-based model
module tb_qcl_edge_event_capture;
    import qcl_edge_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sig = 8'h00, rise = 8'hFF, fall = 8'h00, clr = 8'h00;
    logic [7:0] det [3], lvl [3], pnd [3], ovf [3];
    logic       irq [3];
    bit         go = 1'b0;
    int         n_chk = 0, n_fail = 0;

    // instance 0: filter 1 reset 0, instance 1: filter 4 reset 0, instance 2: filter 3 reset 1
    for (genvar g = 0; g < 3; g++) begin : g_dut
        qcl_edge_event_capture #(
            .width_p(8), .filter_p(g == 0 ? 1 : g == 1 ? 4 : 3), .reset_val_p(g == 2)
        ) u_dut (
            .clk_i(clk), .reset_i(rst), .sig_i(sig), .rise_en_i(rise), .fall_en_i(fall),
            .clear_i(clr), .detect_o(det[g]), .level_o(lvl[g]), .pending_o(pnd[g]),
            .overflow_o(ovf[g]), .irq_o(irq[g])
        );
    end

    always #5 clk = ~clk;

    function automatic int fpv(input int g);
        return g == 0 ? 1 : g == 1 ? 4 : 3;
    endfunction

    // model: a channel changes level once its input has disagreed for filter_p consecutive cycles
    bit m_lvl [3][8], m_pnd [3][8], m_ovf [3][8];
    int m_str [3][8];

    function automatic bit m_acc(input int g, input int c);
        return (sig[c] != m_lvl[g][c]) && (m_str[g][c] + 1 >= fpv(g));
    endfunction

    function automatic bit m_det(input int g, input int c);
        return !rst && m_acc(g, c) && (sig[c] ? rise[c] : fall[c]);
    endfunction

    task automatic chk(input string name, input int g, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d: got %h expected %h at %0t", name, g, act, exp, $time);
        end
    endtask

    initial begin : model
        bit d, a, dif;
        forever begin
            @(posedge clk);
            for (int g = 0; g < 3; g++)
                for (int c = 0; c < 8; c++) begin
                    if (rst) begin
                        m_lvl[g][c] = (g == 2);
                        m_str[g][c] = 0;
                        m_pnd[g][c] = 0;
                        m_ovf[g][c] = 0;
                    end else begin
                        d   = m_det(g, c);
                        a   = m_acc(g, c);
                        dif = sig[c] != m_lvl[g][c];
                        m_ovf[g][c] = (m_ovf[g][c] || (d && m_pnd[g][c])) && !clr[c];
                        m_pnd[g][c] = (m_pnd[g][c] && !clr[c]) || d;
                        if (a) m_lvl[g][c] = sig[c];
                        m_str[g][c] = (dif && !a) ? m_str[g][c] + 1 : 0;
                    end
                end
        end
    end

    initial begin : compare
        logic [7:0] e_det, e_lvl, e_pnd, e_ovf;
        forever begin
            @(negedge clk);
            if (go)
                for (int g = 0; g < 3; g++) begin
                    for (int c = 0; c < 8; c++) begin
                        e_det[c] = m_det(g, c);
                        e_lvl[c] = m_lvl[g][c];
                        e_pnd[c] = m_pnd[g][c];
                        e_ovf[c] = m_ovf[g][c];
                    end
                    chk("detect", g, det[g], e_det);
                    chk("level", g, lvl[g], e_lvl);
                    chk("pending", g, pnd[g], e_pnd);
                    chk("overflow", g, ovf[g], e_ovf);
                    chk("irq", g, {7'd0, irq[g]}, {7'd0, |e_pnd});
                end
        end
    end

    task automatic cyc(input logic r, input logic [7:0] s, input logic [7:0] rf, input logic [7:0] ff,
                       input logic [7:0] c);
        @(posedge clk);
        #2;
        rst = r; sig = s; rise = rf; fall = ff; clr = c;
        @(negedge clk);
        #1;
    endtask

    initial begin : stim
        logic [7:0] s, rf, ff, c;
        logic [1:0] mv;
        e_edge_mode mode;
        cyc(1, 8'h00, 8'hFF, 8'h00, 8'h00);
        go = 1'b1;
        chk("reset_level", 2, lvl[2], 8'hFF);
        chk("reset_pend", 0, pnd[0], 8'h00);
        for (int k = 0; k < 3; k++) cyc(0, 8'h00, 8'hFF, 8'h00, 8'h00);
        // single-register behaviour on instance 0, four-cycle filter on instance 1
        cyc(0, 8'h01, 8'hFF, 8'h00, 8'h00);
        chk("legacy_det", 0, det[0], 8'h01);
        chk("filt_det_early", 1, det[1], 8'h00);
        cyc(0, 8'h01, 8'hFF, 8'h00, 8'h00);
        chk("legacy_det_once", 0, det[0], 8'h00);
        chk("legacy_pend", 0, pnd[0], 8'h01);
        chk("legacy_level", 0, lvl[0], 8'h01);
        for (int k = 3; k <= 4; k++) begin
            cyc(0, 8'h01, 8'hFF, 8'h00, 8'h00);
            chk("filt_rise", 1, det[1], k == 4 ? 8'h01 : 8'h00);
        end
        cyc(0, 8'h01, 8'hFF, 8'h00, 8'h00);
        chk("filt_level", 1, lvl[1], 8'h01);
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 8'h00, 8'hFF, 8'hFF, 8'h00);
            chk("filt_fall", 1, det[1], k == 4 ? 8'h01 : 8'h00);
        end
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 8'h01, 8'hFF, 8'hFF, 8'h00);
            chk("glitch_det", 1, det[1], 8'h00);
        end
        cyc(0, 8'h00, 8'hFF, 8'hFF, 8'h00);
        chk("glitch_level", 1, lvl[1], 8'h00);
        // edge masks on instance 0
        cyc(0, 8'hFF, 8'hFF, 8'h0F, 8'h00);
        cyc(0, 8'h00, 8'hFF, 8'h0F, 8'h00);
        chk("mask_fall", 0, det[0], 8'h0F);
        cyc(0, 8'hFF, 8'hFF, 8'h0F, 8'h00);
        chk("mask_rise", 0, det[0], 8'hFF);
        // overflow and clear races on instance 0
        cyc(0, 8'hFF, 8'hFF, 8'h0F, 8'hFF);
        cyc(0, 8'hFF, 8'hFF, 8'h0F, 8'h00);
        chk("clr_pend", 0, pnd[0], 8'h00);
        chk("clr_irq", 0, {7'd0, irq[0]}, 8'h00);
        cyc(0, 8'h00, 8'hFF, 8'h0F, 8'h00);
        cyc(0, 8'hFF, 8'hFF, 8'h0F, 8'h00);
        cyc(0, 8'hFF, 8'hFF, 8'h0F, 8'h00);
        chk("ovf_set", 0, ovf[0], 8'h0F);
        chk("ovf_pend", 0, pnd[0], 8'hFF);
        cyc(0, 8'h00, 8'hFF, 8'h0F, 8'hFF);
        cyc(0, 8'h00, 8'hFF, 8'h0F, 8'h00);
        chk("race_pend", 0, pnd[0], 8'h0F);
        chk("race_ovf", 0, ovf[0], 8'h00);
        cyc(0, 8'h00, 8'hFF, 8'h0F, 8'hFF);
        cyc(0, 8'h00, 8'hFF, 8'h0F, 8'h00);
        chk("clr_all_pend", 0, pnd[0], 8'h00);
        chk("clr_all_irq", 0, {7'd0, irq[0]}, 8'h00);
        // reset in the middle of a filter window
        for (int k = 0; k < 5; k++) cyc(0, 8'h00, 8'hFF, 8'hFF, 8'h00);
        cyc(0, 8'h01, 8'hFF, 8'hFF, 8'h00);
        cyc(0, 8'h01, 8'hFF, 8'hFF, 8'h00);
        cyc(1, 8'h01, 8'hFF, 8'hFF, 8'h00);
        chk("rst_det_forced", 0, det[0] | det[1] | det[2], 8'h00);
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 8'h01, 8'hFF, 8'hFF, 8'h00);
            chk("rst_mid_det", 1, det[1], k == 4 ? 8'h01 : 8'h00);
            if (k == 1) chk("rst_mid_pend", 1, pnd[1] | ovf[1], 8'h00);
            if (k == 3) chk("rst_val1_fall", 2, det[2], 8'hFE);
        end
        // reset value 1: high line after release is quiet, then falls after three cycles
        cyc(1, 8'hFF, 8'hFF, 8'hFF, 8'h00);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 8'hFF, 8'hFF, 8'hFF, 8'h00);
            chk("rv1_quiet", 2, det[2], 8'h00);
        end
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 8'h00, 8'hFF, 8'hFF, 8'h00);
            chk("rv1_fall", 2, det[2], k == 3 ? 8'hFF : 8'h00);
        end
        rf = 8'hFF;
        ff = 8'hFF;
        for (int n = 0; n < 3000; n++) begin
            s = sig;
            for (int b = 0; b < 8; b++) if ($urandom_range(5) == 0) s[b] = ~s[b];
            if ($urandom_range(15) == 0)
                for (int b = 0; b < 8; b++) begin
                    mode  = e_edge_mode'($urandom_range(3));
                    mv    = 2'(mode);
                    rf[b] = mv[0];
                    ff[b] = mv[1];
                end
            c = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            cyc($urandom_range(199) == 0, s, rf, ff, c);
        end
        cyc(0, sig, rf, ff, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
